rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: serialises NREQ requesters onto one RF write port.
// Define RF_WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module rf_wb_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 rf_we,
  output logic [4:0]           rf_addr,
  output logic [31:0]          rf_wdata,
  output logic [31:0]          rf_sel,
  output logic [15:0]          wr_count
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
  logic [DW-1:0]    rf_sel_q, rf_sel_d;
  logic [CW-1:0]    wr_count_q, wr_count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0]  elig_c;
  logic [NREQ-1:0]  mask_c;
  logic [NREQ-1:0]  hi_c;
  logic [NREQ-1:0]  pick_c;
  logic             found_c;
  logic [PTR_W-1:0] win_c;
  logic [AW-1:0]    addr_c;
  logic [DW-1:0]    data_c;

  // The requester holding this cycle's grant is masked so one transaction is never granted twice.
  always_comb begin
    elig_c = req & ~gnt_q;
    mask_c = ~((NREQ'(1) << ptr_q) - NREQ'(1));
    hi_c   = elig_c & mask_c;
    pick_c = (|hi_c) ? hi_c : elig_c;
  end

  // Lowest set bit of pick_c wins; its payload is muxed out alongside.
  always_comb begin
    found_c = |pick_c;
    win_c   = '0;
    addr_c  = '0;
    data_c  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_c[i]) begin
        win_c  = PTR_W'(i);
        addr_c = req_addr[AW*i +: AW];
        data_c = req_data[DW*i +: DW];
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    rf_we_d    = 1'b0;
    rf_sel_d   = '0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    wr_count_d = wr_count_q;
    ptr_d      = ptr_q;
    if (found_c) begin
      gnt_d      = NREQ'(1) << win_c;
      rf_addr_d  = addr_c;
      rf_wdata_d = data_c;
      // A write to $0 completes the handshake but never touches the file.
      rf_we_d    = (addr_c != '0);
      if (rf_we_d) begin
        rf_sel_d   = DW'(1) << addr_c;
        wr_count_d = wr_count_q + CW'(1);
      end
`ifdef RF_WB_ARB_RR_EN
      ptr_d = (win_c == PTR_W'(NREQ - 1)) ? '0 : win_c + PTR_W'(1);
`else
      ptr_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rf_sel_q   <= '0;
      wr_count_q <= '0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_sel_q   <= rf_sel_d;
      wr_count_q <= wr_count_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_sel   = rf_sel_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps plus random traffic against a reference model.
module tb_rf_wb_arbiter;

  localparam int unsigned NREQ = 3;
`ifdef RF_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req;
  logic [NREQ*5-1:0]   req_addr;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                rf_we;
  logic [4:0]          rf_addr;
  logic [31:0]         rf_wdata;
  logic [31:0]         rf_sel;
  logic [15:0]         wr_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          m_gnt;
  int          m_ptr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_we;
  logic [31:0] m_sel;
  int          m_cnt;

  rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_sel   (rf_sel),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt  = -1;
    m_ptr  = 0;
    m_addr = '0;
    m_data = '0;
    m_we   = 1'b0;
    m_sel  = '0;
    m_cnt  = 0;
  endtask

  // One rising edge: search from the pointer, skipping the requester granted last cycle.
  task automatic model_edge();
    int w;
    int start;
    int i;
    w = -1;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      i = (start + k) % int'(NREQ);
      if (w < 0 && req[i] && (m_gnt != i)) w = i;
    end
    if (w >= 0) begin
      m_gnt  = w;
      m_addr = req_addr[5*w +: 5];
      m_data = req_data[32*w +: 32];
      m_we   = (m_addr != 5'd0);
      m_sel  = m_we ? (32'd1 << m_addr) : 32'd0;
      if (m_we) m_cnt = (m_cnt + 1) % 65536;
      if (RR) m_ptr = (w + 1) % int'(NREQ);
    end else begin
      m_gnt = -1;
      m_we  = 1'b0;
      m_sel = '0;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gnt"},      32'(gnt),      (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    chk({tag, ".rf_we"},    32'(rf_we),    32'(m_we));
    chk({tag, ".rf_addr"},  32'(rf_addr),  32'(m_addr));
    chk({tag, ".rf_wdata"}, rf_wdata,      m_data);
    chk({tag, ".rf_sel"},   rf_sel,        m_sel);
    chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
  endtask

  task automatic cyc(input bit do_chk, input string tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
    if (do_chk) chk_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    model_reset();
    #1;
    chk_model("reset_pulse");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_addr[5*i +: 5]   = a;
    req_data[32*i +: 32] = d;
  endtask

  logic [NREQ-1:0] seq_exp [4];

  initial begin
    req = '0;
    req_addr = '0;
    req_data = '0;
    model_reset();
    if (RR) seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    else    seq_exp = '{3'b001, 3'b010, 3'b001, 3'b010};

    // reset asserted with all requesters active: outputs cleared without a clock edge
    #1 rst = 1'b0;
    set_req(0, 5'd3, 32'hA000_0000);
    set_req(1, 5'd4, 32'hA000_0001);
    set_req(2, 5'd5, 32'hA000_0002);
    #2;
    chk_model("async_rst");
    repeat (2) cyc(1'b1, "in_rst");
    @(negedge clk);
    rst = 1'b1;

    // first grant after release, then contention sequence with req held
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, "contend");
      chk("contend_seq", 32'(gnt), 32'(seq_exp[k]));
    end
    req = '0;
    cyc(1'b1, "idle");
    chk("idle_we", 32'(rf_we), 32'd0);

    // single request
    do_reset();
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    cyc(1'b1, "single");
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_addr", 32'(rf_addr), 32'd7);
    chk("single_sel", rf_sel, 32'h0000_0080);
    chk("single_cnt", 32'(wr_count), 32'd1);

    // write to $0 completes handshake without a write
    req = '0;
    set_req(0, 5'd0, 32'h0000_1234);
    cyc(1'b1, "zero");
    chk("zero_gnt", 32'(gnt), 32'h1);
    chk("zero_we", 32'(rf_we), 32'd0);
    chk("zero_sel", rf_sel, 32'd0);
    chk("zero_cnt", 32'(wr_count), 32'd1);
    req = '0;
    cyc(1'b1, "zero_idle");

    // random traffic: requesters hold until granted, then drop or present a new transaction
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (m_gnt == i || !req[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          req_addr[5*i +: 5]   = 5'($urandom_range(0, 31));
          req_data[32*i +: 32] = $urandom;
        end
      end
      cyc(1'b1, "rand");
    end

    // wrap of the write counter
    do_reset();
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd1, 32'h2);
    set_req(2, 5'd1, 32'h3);
    repeat (65535) cyc(1'b0, "wrap_fill");
    chk_model("wrap_full");
    chk("wrap_ffff", 32'(wr_count), 32'h0000_FFFF);
    cyc(1'b1, "wrap_roll");
    chk("wrap_zero", 32'(wr_count), 32'd0);

    // reset between selection of requester 2 and its grant cycle
    req = '0;
    cyc(1'b1, "pre_mid");
    set_req(1, 5'd3, 32'h0000_0033);
    cyc(1'b1, "mid_g1");
    req = '0;
    set_req(2, 5'd31, 32'hCAFE_F00D);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_we", 32'(rf_we), 32'd0);
    chk("mid_sel", rf_sel, 32'd0);
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk_model("mid_rst");
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      cyc(1'b1, "post_mid");
      chk("post_mid_we", 32'(rf_we), 32'd0);
    end
    set_req(0, 5'd9, 32'h0000_0009);
    set_req(1, 5'd10, 32'h0000_000A);
    set_req(2, 5'd11, 32'h0000_000B);
    cyc(1'b1, "ptr_after_rst");
    chk("ptr_zero_gnt", 32'(gnt), 32'h1);
    req = '0;
    cyc(1'b1, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
